vending_controller: RTL
=======================

Name: vending_controller

Overview:
- Credit/dispense sequencer for the vending datapath.
- Accepts coins one at a time over a valid/ready handshake and tracks credit in nickel units.
- Issues one dispense request once credit reaches PRICE, then pays back any remainder one coin at a time over a change handshake.
- Sits between the coin-acceptor front end, the product dispenser and the change hopper.

Parameters:
- PRICE, 4, item price in nickels; 1 <= PRICE <= MAX_CREDIT.
- MAX_CREDIT, 7, maximum credit held in nickels; MAX_CREDIT < 2^CREDIT_W.
- CREDIT_W, 4, credit register width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_coin_valid  in  1  coin present.
- io_coin_type  in  2  0 nickel(1), 1 dime(2), 2 quarter(5), 3 slug/invalid.
- io_coin_ready  out  1  coin accepted this cycle when valid&ready.
- io_cancel  in  1  refund request, level.
- io_dispense_valid  out  1  dispense one item.
- io_dispense_ready  in  1  dispenser accepts.
- io_change_valid  out  1  return one coin.
- io_change_coin  out  1  0 nickel, 1 dime.
- io_change_ready  in  1  hopper accepts.
- io_credit  out  CREDIT_W  current credit, registered.
- io_reject  out  1  one-cycle pulse: last accepted coin was rejected (returned mechanically).
- io_vend_count  out  8  items dispensed since reset, wraps 255->0.

Behaviour:
- Reset (reset=0, async): state=COLLECT, credit=0, io_reject=0, io_vend_count=0. All valid outputs are 0 while in reset. io_coin_ready is 1 the first cycle after release.
- States: COLLECT, DISPENSE, CHANGE. All outputs are decoded from registered state/credit; no combinational path from any input to any valid output.
- io_coin_ready = (state==COLLECT) && !io_cancel. Cancel has priority over a same-cycle coin; that coin is not consumed.
- COLLECT, coin handshake:
  - value = type decode.
  - If type==3 or credit+value > MAX_CREDIT: credit unchanged; io_reject=1 next cycle only.
  - Otherwise credit <= credit+value. If the new credit >= PRICE, next state = DISPENSE.
- COLLECT, cancel:
  - credit>0: next state = CHANGE.
  - credit==0: cancel is ignored.
- DISPENSE:
  - io_dispense_valid=1, held stable until io_dispense_ready.
  - On handshake: credit <= credit-PRICE; io_vend_count++ (mod 256).
  - Next state = CHANGE if the remainder > 0, else COLLECT.
  - Cancel and coins are ignored (coin_ready=0).
- CHANGE:
  - io_change_valid=1; io_change_coin = (credit>=2).
  - On handshake: credit -= 2 or 1. When credit reaches 0, next state = COLLECT.
  - Coin and valid are held stable while ready is low.
- Latency: coin handshake at cycle N -> io_credit updated at N+1; io_dispense_valid asserted at N+1 when the threshold is crossed. Dispense handshake at N -> io_change_valid at N+1 if a remainder exists.
- Arithmetic: credit+value is computed at CREDIT_W+1 bits so there is no wrap before the compare.
- Reset mid-transaction: pending dispense/change is abandoned, credit lost; no output glitches high.

Decomposition:
- Shared package vending_pkg holds:
  - state enum {COLLECT, DISPENSE, CHANGE};
  - coin type codes;
  - coin values (1/2/5);
  - change coin codes.
- One natural sub-module: vending_coin_decode (type -> value, invalid flag), reusable by the coin-acceptor front end.
- Credit/FSM logic stays in vending_controller.

Test Plan (PRICE=4, MAX_CREDIT=7):
- Reset held low 3 cycles then released -> io_credit=0, all valids 0, io_coin_ready=1, io_vend_count=0.
- 4 nickels -> credit 1,2,3,4. Dispense_valid rises the cycle after the 4th coin. With ready=0 for 3 cycles, valid is held. On ready: credit=0, vend_count=1, back to COLLECT, no change_valid.
- One quarter -> credit 5, dispense. After handshake credit=1, CHANGE with change_coin=0 (nickel) once, then COLLECT.
- Nickel, dime (credit 3), quarter -> 8>7: io_reject pulses 1 cycle, credit stays 3. Then dime -> credit 5 -> dispense -> change nickel.
- Credit 3 then cancel asserted with coin_valid high -> coin_ready=0, coin not taken. Change dime (credit 1) then nickel (credit 0), COLLECT; vend_count unchanged.
- reset=0 asynchronously during CHANGE with change_ready=0 -> change_valid and credit go to 0 immediately; after release, state is COLLECT.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending credit/dispense path.
// Coin value decoding is reused by the coin-acceptor front end.
package vending_pkg;

    typedef enum logic [1:0] {
        StCollect,
        StDispense,
        StChange
    } state_e;

    typedef enum logic [1:0] {
        CoinNickel  = 2'd0,
        CoinDime    = 2'd1,
        CoinQuarter = 2'd2,
        CoinSlug    = 2'd3
    } coin_type_e;

    localparam logic [2:0] NickelValue  = 3'd1;
    localparam logic [2:0] DimeValue    = 3'd2;
    localparam logic [2:0] QuarterValue = 3'd5;

    localparam logic ChangeNickel = 1'b0;
    localparam logic ChangeDime   = 1'b1;

endpackage

// File: rtl/vending_coin_decode.sv
// Maps a coin type code to its value in nickels and flags slugs.
module vending_coin_decode
    import vending_pkg::*;
(
    input  logic [1:0] coin_type_i,
    output logic [2:0] value_o,
    output logic       invalid_o
);

    always_comb begin
        value_o   = 3'd0;
        invalid_o = 1'b0;
        case (coin_type_i)
            CoinNickel:  value_o = NickelValue;
            CoinDime:    value_o = DimeValue;
            CoinQuarter: value_o = QuarterValue;
            default:     invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/vending_controller.sv
// Credit/dispense sequencer: collects coins, requests one dispense at PRICE,
// then returns any remaining credit one coin at a time.
module vending_controller
    import vending_pkg::*;
#(
    parameter int unsigned PRICE      = 4,
    parameter int unsigned MAX_CREDIT = 7,
    parameter int unsigned CREDIT_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_coin_valid,
    input  logic [1:0]          io_coin_type,
    output logic                io_coin_ready,
    input  logic                io_cancel,
    output logic                io_dispense_valid,
    input  logic                io_dispense_ready,
    output logic                io_change_valid,
    output logic                io_change_coin,
    input  logic                io_change_ready,
    output logic [CREDIT_W-1:0] io_credit,
    output logic                io_reject,
    output logic [7:0]          io_vend_count
);

    localparam logic [CREDIT_W:0]   MaxCreditW = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PriceC     = CREDIT_W'(PRICE);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic [7:0]          vend_q, vend_d;

    logic [2:0]          coin_value;
    logic                coin_invalid;
    logic [CREDIT_W:0]   credit_sum;
    logic                change_dime;

    vending_coin_decode u_coin_decode (
        .coin_type_i (io_coin_type),
        .value_o     (coin_value),
        .invalid_o   (coin_invalid)
    );

    // One extra bit so an overflowing coin is caught before it can wrap.
    assign credit_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value);
    assign change_dime = (credit_q >= CREDIT_W'(2)) ? ChangeDime : ChangeNickel;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        vend_d   = vend_q;
        case (state_q)
            StCollect: begin
                if (io_cancel) begin
                    if (credit_q != '0) begin
                        state_d = StChange;
                    end
                end else if (io_coin_valid) begin
                    if (coin_invalid || (credit_sum > MaxCreditW)) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        if (credit_sum >= {1'b0, PriceC}) begin
                            state_d = StDispense;
                        end
                    end
                end
            end
            StDispense: begin
                if (io_dispense_ready) begin
                    credit_d = credit_q - PriceC;
                    vend_d   = vend_q + 8'd1;
                    state_d  = (credit_q != PriceC) ? StChange : StCollect;
                end
            end
            StChange: begin
                if (io_change_ready) begin
                    credit_d = credit_q - (change_dime ? CREDIT_W'(2) : CREDIT_W'(1));
                    if (credit_d == '0) begin
                        state_d = StCollect;
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StCollect;
            credit_q <= '0;
            reject_q <= 1'b0;
            vend_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
            vend_q   <= vend_d;
        end
    end

    assign io_coin_ready     = (state_q == StCollect) && !io_cancel;
    assign io_dispense_valid = (state_q == StDispense);
    assign io_change_valid   = (state_q == StChange);
    assign io_change_coin    = (state_q == StChange) && change_dime;
    assign io_credit         = credit_q;
    assign io_reject         = reject_q;
    assign io_vend_count     = vend_q;

endmodule
